pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Parametrised instruction-fetch stage for the pipelined ARM processor. It replaces the externally driven PC and adder with an internal program counter, an instruction-memory request port and a small fetch queue feeding the IF/ID boundary. It supports decode back-pressure through a valid/ready handshake and branch redirects that squash all in-flight work.

## Interface
- `ADDR_WIDTH`, 64: PC and address width.
- `INSTR_WIDTH`, 32: instruction word width.
- `INCREMENT`, 4: PC step per sequential fetch.
- `RESET_PC`, 0: PC value after reset.
- `QUEUE_DEPTH`, 4: fetch-queue entries; a power of two, at least 2.

- `clock` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `imem_rd_en` out 1: instruction-memory read request this cycle.
- `imem_addr` out ADDR_WIDTH: request address; equals the current PC.
- `imem_rdata` in INSTR_WIDTH: read data, valid exactly one cycle after the request.
- `br_taken` in 1: redirect strobe from the execute stage.
- `br_target` in ADDR_WIDTH: redirect address, used unmodified.
- `if_valid` out 1: the queue head holds a valid instruction.
- `id_ready` in 1: decode accepts the head this cycle.
- `if_pc` out ADDR_WIDTH: PC of the head instruction.
- `if_pc_plus` out ADDR_WIDTH: `if_pc + INCREMENT`, modulo 2^ADDR_WIDTH.
- `if_instr` out INSTR_WIDTH: head instruction word.
- `fetch_count` out 32: count of instructions accepted by decode (see Configuration).
- `redirect_count` out 32: count of redirects (see Configuration).

## Operation
- **State:** `pc`, an in-flight flag with its request PC, and a FIFO with read/write pointers and an occupancy count.
- **Issue rule:** `imem_rd_en = !br_taken && (count + inflight) < QUEUE_DEPTH`. When issuing, `pc <= pc + INCREMENT`, wrapping modulo 2^ADDR_WIDTH.
- **Response:** one cycle after an issue, the pair {request PC, `imem_rdata`} is pushed at the end of that cycle, unless that cycle is a redirect.
- **Pop:** occurs when `if_valid && id_ready`. Push and pop in the same cycle leave the count unchanged. The head outputs come straight from storage with no extra register.
- **Redirect (`br_taken` in cycle t):**
  - no issue in cycle t;
  - the response arriving in cycle t is discarded;
  - the FIFO is emptied and `pc <= br_target`;
  - any pop in cycle t still counts as consumed by decode.
  - Redirect has priority over issue, push and pop bookkeeping.
- **Back-pressure:** while `id_ready` is low, the head and `if_valid` hold stable. Issuing continues until `count + inflight` reaches QUEUE_DEPTH, then stops. No entry is ever overwritten or dropped.
- **Reset values (`reset_n` low, any time, asynchronous):**
  - `pc = RESET_PC`, FIFO empty, in-flight flag cleared;
  - `imem_rd_en = 0`, `imem_addr = RESET_PC`;
  - `if_valid = 0`, `if_pc`, `if_instr` and `if_pc_plus` read 0 from cleared storage;
  - both counters 0.
  - A response to a request issued before a mid-operation reset is never pushed.

## Timing
- **Fetch latency:** request in cycle r, data in r+1, pushed at the end of r+1, `if_valid` in r+2.
- **First request:** in the first cycle after `reset_n` deasserts; the first `if_valid` follows 2 cycles later.
- **Redirect penalty:** for `br_taken` in cycle t, the target request goes out in t+1 and `if_valid` for the target rises in t+3. Cycles t+1 and t+2 show `if_valid = 0`.
- **Steady-state throughput:** one instruction per cycle while `id_ready` stays high.
- **Combinational paths:** `imem_rd_en` depends combinationally on `br_taken`. No other input-to-output combinational path exists.

## Configuration
- **`FETCH_PERF_COUNTERS_EN` defined:**
  - `fetch_count` increments on every pop;
  - `redirect_count` increments on every `br_taken` cycle;
  - both wrap at 2^32 and reset to 0.
- **Not defined:** both outputs are tied to 0 and no counter flops are built. All other behaviour is identical.

## Test plan
- **Reset then run, `id_ready` = 1:** imem returns `addr >> 2`. Expect `if_valid` in cycle 2 with `if_pc` = 0, 4, 8, … one per cycle, `if_instr` = 0, 1, 2, and `if_pc_plus` = 4, 8, 12.
- **Hold `id_ready` = 0 for 10 cycles, then release:** exactly QUEUE_DEPTH requests are issued and the head stays at PC 0 throughout. After release, PCs 0, 4, 8, 12, 16 pop consecutively with no gap or duplicate.
- **Redirect:** `br_taken` with `br_target` = 0x100 while the queue holds 3 entries and a request is in flight. Expect `if_valid` = 0 for 2 cycles, then `if_pc` = 0x100, 0x104. No old PC appears.
- **Wrap-around:** redirect to 0xFFFF_FFFF_FFFF_FFFC. Expect `if_pc` = 0xFFFF_FFFF_FFFF_FFFC with `if_pc_plus` = 0, followed by `if_pc` = 0.
- **Mid-operation reset:** assert `reset_n` = 0 between clock edges during streaming. Expect `if_valid` and `imem_rd_en` low immediately. After release, fetch restarts at RESET_PC and the stale response is not delivered.
- **With `FETCH_PERF_COUNTERS_EN`:** 20 pops and 3 redirects give `fetch_count` = 20 and `redirect_count` = 3. Without the macro, both read 0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Instruction-fetch stage: owns the program counter, issues one instruction
// memory read per cycle while there is room, and buffers the returned words in
// a small FIFO that feeds the IF/ID boundary through a valid/ready handshake.
// A branch redirect squashes the in-flight request and empties the FIFO.
//
// Optional feature macro: FETCH_PERF_COUNTERS_EN
//   defined   -> fetch_count / redirect_count are live 32-bit wrapping counters
//   undefined -> both outputs are tied to zero and no counter flops exist
//
// Ports
//   clock          in   rising-edge clock
//   reset_n        in   asynchronous active-low reset
//   imem_rd_en     out  instruction memory read request this cycle
//   imem_addr      out  request address (current pc)
//   imem_rdata     in   read data, valid one cycle after the request
//   br_taken       in   redirect strobe from execute
//   br_target      in   redirect address
//   if_valid       out  FIFO head holds a valid instruction
//   id_ready       in   decode accepts the head this cycle
//   if_pc          out  pc of the head instruction
//   if_pc_plus     out  head pc + INCREMENT
//   if_instr       out  head instruction word
//   fetch_count    out  instructions accepted by decode
//   redirect_count out  redirects seen
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter int                    ADDR_WIDTH  = 64,
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    INCREMENT   = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    QUEUE_DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  output logic                   imem_rd_en,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   br_taken,
  input  logic [ADDR_WIDTH-1:0]  br_target,
  output logic                   if_valid,
  input  logic                   id_ready,
  output logic [ADDR_WIDTH-1:0]  if_pc,
  output logic [ADDR_WIDTH-1:0]  if_pc_plus,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [31:0]            fetch_count,
  output logic [31:0]            redirect_count
);

  localparam int                    PTR_W = $clog2(QUEUE_DEPTH);
  localparam int                    CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] INC   = ADDR_WIDTH'(INCREMENT);

  logic [ADDR_WIDTH-1:0]  pc;
  logic                   vld_p1;
  logic [ADDR_WIDTH-1:0]  pc_p1;

  logic [ADDR_WIDTH-1:0]  q_pc      [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0]  q_pc_plus [QUEUE_DEPTH];
  logic [INSTR_WIDTH-1:0] q_instr   [QUEUE_DEPTH];
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [CNT_W-1:0]       count;

  logic [CNT_W:0]         occupancy;
  logic                   issue;
  logic                   push;
  logic                   pop;

  // Entries already buffered plus the one still coming back from memory;
  // issuing only while this is below depth guarantees a push never overflows.
  assign occupancy = {1'b0, count} + (CNT_W+1)'(vld_p1);
  assign issue     = !br_taken && (occupancy < (CNT_W+1)'(QUEUE_DEPTH));
  assign push      = vld_p1 && !br_taken;
  assign pop       = if_valid && id_ready;

  // The request strobe is forced low while reset is held so nothing leaves
  // the block before the first clean cycle.
  assign imem_rd_en = issue && reset_n;
  assign imem_addr  = pc;

  assign if_valid   = (count != '0);
  assign if_pc      = q_pc[rd_ptr];
  assign if_pc_plus = q_pc_plus[rd_ptr];
  assign if_instr   = q_instr[rd_ptr];

  // ---- stage p0 -> p1: request issue, pc advance, FIFO bookkeeping ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc     <= RESET_PC;
      vld_p1 <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (br_taken) begin
      pc     <= br_target;
      vld_p1 <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      vld_p1 <= issue;
      if (issue) pc <= pc + INC;
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (issue) pc_p1 <= pc;
  end

  // ---- stage p1 -> FIFO: capture {pc, pc+INCREMENT, word} on response ----
  // Storage is cleared on reset so the head outputs read zero afterwards.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_pc[i]      <= '0;
        q_pc_plus[i] <= '0;
        q_instr[i]   <= '0;
      end
    end else if (push) begin
      q_pc[wr_ptr]      <= pc_p1;
      q_pc_plus[wr_ptr] <= pc_p1 + INC;
      q_instr[wr_ptr]   <= imem_rdata;
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] redir_cnt_q;

  // A pop in a redirect cycle still counts as consumed by decode.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      if (pop)      fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (br_taken) redir_cnt_q <= redir_cnt_q + 32'd1;
    end
  end

  assign fetch_count    = fetch_cnt_q;
  assign redirect_count = redir_cnt_q;
`else
  assign fetch_count    = '0;
  assign redirect_count = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Self-checking bench for pc_fetch_unit. Instruction memory returns addr >> 2.
// A queue-based reference model tracks the expected program counter, the
// outstanding request and the list of buffered PCs; directed scenarios also
// check the fixed timing from reset and around redirects.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

  localparam int             AW       = 64;
  localparam int             IW       = 32;
  localparam int             INC      = 4;
  localparam int             QD       = 4;
  localparam logic [AW-1:0]  RESET_PC = '0;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          imem_rd_en;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata = '0;
  logic          br_taken = 1'b0;
  logic [AW-1:0] br_target = '0;
  logic          if_valid;
  logic          id_ready = 1'b0;
  logic [AW-1:0] if_pc;
  logic [AW-1:0] if_pc_plus;
  logic [IW-1:0] if_instr;
  logic [31:0]   fetch_count;
  logic [31:0]   redirect_count;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit #(
    .ADDR_WIDTH (AW),
    .INSTR_WIDTH(IW),
    .INCREMENT  (INC),
    .RESET_PC   (RESET_PC),
    .QUEUE_DEPTH(QD)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .imem_rd_en    (imem_rd_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .if_valid      (if_valid),
    .id_ready      (id_ready),
    .if_pc         (if_pc),
    .if_pc_plus    (if_pc_plus),
    .if_instr      (if_instr),
    .fetch_count   (fetch_count),
    .redirect_count(redirect_count)
  );

  always #5 clock = ~clock;

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return IW'(a >> 2);
  endfunction

  // Memory answers one cycle after the address is presented.
  always @(posedge clock) imem_rdata <= mem_word(imem_addr);

  // ---------------- reference model ----------------
  logic [AW-1:0] m_pc;
  bit            m_inf;
  logic [AW-1:0] m_inf_pc;
  logic [AW-1:0] m_q[$];
  logic [31:0]   m_fetch;
  logic [31:0]   m_redir;

  task automatic model_reset();
    m_pc     = RESET_PC;
    m_inf    = 1'b0;
    m_inf_pc = '0;
    m_q.delete();
    m_fetch  = '0;
    m_redir  = '0;
  endtask

  function automatic bit exp_issue();
    return !br_taken && ((m_q.size() + int'(m_inf)) < QD);
  endfunction

  function automatic logic [31:0] exp_fc();
`ifdef FETCH_PERF_COUNTERS_EN
    return m_fetch;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_rc();
`ifdef FETCH_PERF_COUNTERS_EN
    return m_redir;
`else
    return 32'd0;
`endif
  endfunction

  // Advance the model across the next rising edge using the inputs now driven.
  task automatic model_step();
    bit            pop;
    bit            iss;
    bit            br;
    logic [AW-1:0] tgt;
    pop = (m_q.size() != 0) && id_ready;
    iss = exp_issue();
    br  = br_taken;
    tgt = br_target;
    @(posedge clock);
    if (pop) m_fetch = m_fetch + 32'd1;
    if (br) begin
      m_redir = m_redir + 32'd1;
      m_q.delete();
      m_inf = 1'b0;
      m_pc  = tgt;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_inf) m_q.push_back(m_inf_pc);
      m_inf    = iss;
      m_inf_pc = m_pc;
      if (iss) m_pc = m_pc + AW'(INC);
    end
    #1;
  endtask

  task automatic apply_reset();
    br_taken = 1'b0;
    id_ready = 1'b0;
    reset_n  = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    br_taken = 1'b0;
    id_ready = 1'b0;
    #1;
    reset_n = 1'b0;
    #2;
    checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %0b exp 0", imem_rd_en); end
    checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr got %h exp %h", imem_addr, RESET_PC); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", if_valid); end
    checks++; if (if_pc !== '0) begin errors++; $display("FAIL reset_if_pc got %h exp 0", if_pc); end
    checks++; if (if_instr !== '0) begin errors++; $display("FAIL reset_if_instr got %h exp 0", if_instr); end
    checks++; if (if_pc_plus !== '0) begin errors++; $display("FAIL reset_if_pc_plus got %h exp 0", if_pc_plus); end
    checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_fetch_count got %0d exp 0", fetch_count); end
    checks++; if (redirect_count !== 32'd0) begin errors++; $display("FAIL reset_redirect_count got %0d exp 0", redirect_count); end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_stream();
    id_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (c == 0) begin
        checks++; if (imem_rd_en !== 1'b1 || imem_addr !== RESET_PC) begin
          errors++; $display("FAIL stream_first_req rd_en %0b addr %h exp 1 %h", imem_rd_en, imem_addr, RESET_PC);
        end
      end
      if (c < 2) begin
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid cyc %0d got %0b exp 0", c, if_valid); end
      end else begin
        checks++; if (if_valid !== 1'b1 || if_pc !== AW'((c-2)*4)) begin
          errors++; $display("FAIL stream_head cyc %0d valid %0b pc %h exp 1 %h", c, if_valid, if_pc, AW'((c-2)*4));
        end
        checks++; if (if_instr !== IW'(c-2) || if_pc_plus !== AW'((c-1)*4)) begin
          errors++; $display("FAIL stream_data cyc %0d instr %h plus %h exp %h %h", c, if_instr, if_pc_plus, IW'(c-2), AW'((c-1)*4));
        end
      end
      model_step();
    end
  endtask

  task automatic test_backpressure();
    int issued;
    apply_reset();
    id_ready = 1'b0;
    issued = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (imem_rd_en === 1'b1) issued++;
      checks++; if (imem_rd_en !== exp_issue()) begin errors++; $display("FAIL bp_rd_en cyc %0d got %0b exp %0b", c, imem_rd_en, exp_issue()); end
      if (m_q.size() != 0) begin
        checks++; if (if_valid !== 1'b1 || if_pc !== RESET_PC) begin
          errors++; $display("FAIL bp_head cyc %0d valid %0b pc %h exp 1 %h", c, if_valid, if_pc, RESET_PC);
        end
      end
      model_step();
    end
    checks++; if (issued != QD) begin errors++; $display("FAIL bp_issue_count got %0d exp %0d", issued, QD); end
    id_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      checks++; if (if_valid !== 1'b1 || if_pc !== AW'(k*4)) begin
        errors++; $display("FAIL bp_release pop %0d valid %0b pc %h exp 1 %h", k, if_valid, if_pc, AW'(k*4));
      end
      model_step();
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    id_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      model_step();
    end
    // Three buffered entries and one outstanding request: issue must stall.
    @(negedge clock);
    checks++; if (if_valid !== 1'b1 || imem_rd_en !== 1'b0) begin
      errors++; $display("FAIL redir_pre valid %0b rd_en %0b exp 1 0", if_valid, imem_rd_en);
    end
    br_taken  = 1'b1;
    br_target = 64'h100;
    id_ready  = 1'b1;
    #1;
    checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL redir_no_issue got %0b exp 0", imem_rd_en); end
    model_step();
    br_taken = 1'b0;
    @(negedge clock);
    checks++; if (if_valid !== 1'b0 || imem_rd_en !== 1'b1 || imem_addr !== 64'h100) begin
      errors++; $display("FAIL redir_t1 valid %0b rd_en %0b addr %h exp 0 1 100", if_valid, imem_rd_en, imem_addr);
    end
    model_step();
    @(negedge clock);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_t2 valid got %0b exp 0", if_valid); end
    model_step();
    @(negedge clock);
    checks++; if (if_valid !== 1'b1 || if_pc !== 64'h100) begin
      errors++; $display("FAIL redir_t3 valid %0b pc %h exp 1 100", if_valid, if_pc);
    end
    model_step();
    @(negedge clock);
    checks++; if (if_valid !== 1'b1 || if_pc !== 64'h104) begin
      errors++; $display("FAIL redir_t4 valid %0b pc %h exp 1 104", if_valid, if_pc);
    end
    model_step();
  endtask

  task automatic test_wrap();
    id_ready  = 1'b1;
    br_taken  = 1'b1;
    br_target = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clock);
    model_step();
    br_taken = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      model_step();
    end
    @(negedge clock);
    checks++; if (if_valid !== 1'b1 || if_pc !== 64'hFFFF_FFFF_FFFF_FFFC || if_pc_plus !== 64'h0) begin
      errors++; $display("FAIL wrap_top valid %0b pc %h plus %h exp 1 fffffffffffffffc 0", if_valid, if_pc, if_pc_plus);
    end
    checks++; if (if_instr !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_instr got %h exp ffffffff", if_instr); end
    model_step();
    @(negedge clock);
    checks++; if (if_valid !== 1'b1 || if_pc !== 64'h0) begin
      errors++; $display("FAIL wrap_zero valid %0b pc %h exp 1 0", if_valid, if_pc);
    end
    model_step();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      id_ready = ($urandom_range(0, 9) < 7);
      br_taken = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) br_target = 64'hFFFF_FFFF_FFFF_FFF0 | AW'($urandom_range(0, 3) * 4);
      else                           br_target = {$urandom, $urandom} & ~64'h3;
      @(negedge clock);
      checks++; if (imem_rd_en !== exp_issue()) begin errors++; $display("FAIL rnd_rd_en cyc %0d got %0b exp %0b", c, imem_rd_en, exp_issue()); end
      checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr cyc %0d got %h exp %h", c, imem_addr, m_pc); end
      checks++; if (if_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc %0d got %0b exp %0b", c, if_valid, m_q.size() != 0); end
      if (m_q.size() != 0) begin
        checks++; if (if_pc !== m_q[0]) begin errors++; $display("FAIL rnd_if_pc cyc %0d got %h exp %h", c, if_pc, m_q[0]); end
        checks++; if (if_instr !== mem_word(m_q[0])) begin errors++; $display("FAIL rnd_if_instr cyc %0d got %h exp %h", c, if_instr, mem_word(m_q[0])); end
        checks++; if (if_pc_plus !== m_q[0] + AW'(INC)) begin errors++; $display("FAIL rnd_if_pc_plus cyc %0d got %h exp %h", c, if_pc_plus, m_q[0] + AW'(INC)); end
      end
      checks++; if (fetch_count !== exp_fc()) begin errors++; $display("FAIL rnd_fetch_count cyc %0d got %0d exp %0d", c, fetch_count, exp_fc()); end
      checks++; if (redirect_count !== exp_rc()) begin errors++; $display("FAIL rnd_redirect_count cyc %0d got %0d exp %0d", c, redirect_count, exp_rc()); end
      model_step();
    end
    br_taken = 1'b0;
  endtask

  task automatic test_mid_reset();
    apply_reset();
    id_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      model_step();
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b0 || imem_rd_en !== 1'b0) begin
      errors++; $display("FAIL midrst_immediate valid %0b rd_en %0b exp 0 0", if_valid, imem_rd_en);
    end
    checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL midrst_addr got %h exp %h", imem_addr, RESET_PC); end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (c < 2) begin
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale cyc %0d valid %0b pc %h exp 0", c, if_valid, if_pc); end
      end else begin
        checks++; if (if_valid !== 1'b1 || if_pc !== AW'((c-2)*4)) begin
          errors++; $display("FAIL midrst_restart cyc %0d valid %0b pc %h exp 1 %h", c, if_valid, if_pc, AW'((c-2)*4));
        end
      end
      model_step();
    end
  endtask

  task automatic test_counters();
    logic [31:0] exp_f;
    logic [31:0] exp_r;
    apply_reset();
    id_ready = 1'b1;
    for (int c = 0; c < 200 && m_fetch < 32'd20; c++) begin
      br_taken  = (c == 5 || c == 12 || c == 18);
      br_target = AW'(32'h2000 + c * 64);
      @(negedge clock);
      model_step();
    end
    br_taken = 1'b0;
    @(negedge clock);
`ifdef FETCH_PERF_COUNTERS_EN
    exp_f = 32'd20;
    exp_r = 32'd3;
`else
    exp_f = 32'd0;
    exp_r = 32'd0;
`endif
    checks++; if (fetch_count !== exp_f) begin errors++; $display("FAIL cnt_fetch got %0d exp %0d", fetch_count, exp_f); end
    checks++; if (redirect_count !== exp_r) begin errors++; $display("FAIL cnt_redirect got %0d exp %0d", redirect_count, exp_r); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_random();
    test_mid_reset();
    test_counters();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
